riscv_irq_arbiter: RTL and testbench

RISCV_IRQ_ARBITER -- requirements
Module: riscv_irq_arbiter

---
 rtl/riscv_irq_arbiter_if.sv | 33 +++
 rtl/riscv_irq_arbiter.sv | 131 +++++++++++++
 tb/tb_riscv_irq_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_irq_arbiter_if.sv
// Interrupt arbiter bundle: level lines, enables and controller handshake.
// The arbiter uses the slave modport; the interrupt source/controller side uses master.
interface riscv_irq_arbiter_if #(
  parameter int NUM_IRQ = 32
);
  localparam int ID_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_mask_i;
  logic [NUM_IRQ-1:0] irq_sec_i;
  logic               m_ie_i;
  logic               u_ie_i;
  logic [1:0]         priv_lvl_i;
  logic               ctrl_ack_i;
  logic               ctrl_kill_i;
  logic               irq_req_o;
  logic [ID_W-1:0]    irq_id_o;
  logic               irq_sec_o;
  logic [NUM_IRQ-1:0] irq_onehot_o;
  logic [NUM_IRQ-1:0] irq_pending_o;

  modport master (
    output irq_i, irq_mask_i, irq_sec_i, m_ie_i, u_ie_i, priv_lvl_i,
           ctrl_ack_i, ctrl_kill_i,
    input  irq_req_o, irq_id_o, irq_sec_o, irq_onehot_o, irq_pending_o
  );

  modport slave (
    input  irq_i, irq_mask_i, irq_sec_i, m_ie_i, u_ie_i, priv_lvl_i,
           ctrl_ack_i, ctrl_kill_i,
    output irq_req_o, irq_id_o, irq_sec_o, irq_onehot_o, irq_pending_o
  );
endinterface

// File: rtl/riscv_irq_arbiter.sv
// Level-triggered interrupt arbiter: highest pending id wins, is captured and
// held for the controller until it is acknowledged or killed.
module riscv_irq_arbiter #(
  parameter int NUM_IRQ     = 32,
  parameter bit PULP_SECURE = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  riscv_irq_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e             state_r;
  state_e             next_state_s;
  logic               req_r;
  logic [ID_W-1:0]    id_r;
  logic               sec_r;
  logic [NUM_IRQ-1:0] onehot_r;
  logic [NUM_IRQ-1:0] pending_r;

  logic [NUM_IRQ-1:0] cand_s;
  logic [ID_W-1:0]    winner_s;
  logic               win_sec_s;
  logic               enable_s;
  logic [ID_W-1:0]    next_id_s;
  logic               next_sec_s;
  logic [NUM_IRQ-1:0] next_onehot_s;

  // Later (higher) set bits overwrite earlier ones, so the highest id wins.
  function automatic logic [ID_W-1:0] find_highest(input logic [NUM_IRQ-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (vec[k]) begin
        idx = ID_W'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Candidate selection and privilege-qualified global enable.
  always_comb begin
    cand_s    = bus.irq_i & bus.irq_mask_i;
    winner_s  = find_highest(cand_s);
    win_sec_s = bus.irq_sec_i[winner_s];
    if (PULP_SECURE) begin
      enable_s = ((bus.priv_lvl_i == 2'b11) & bus.m_ie_i) |
                 ((bus.priv_lvl_i == 2'b00) & (bus.u_ie_i | win_sec_s));
    end else begin
      enable_s = bus.m_ie_i;
    end
  end

  // Next-state and next captured-interrupt fields.
  always_comb begin
    next_state_s  = state_r;
    next_id_s     = id_r;
    next_sec_s    = sec_r;
    next_onehot_s = onehot_r;
    case (state_r)
      IDLE: begin
        if (enable_s && (|cand_s)) begin
          next_state_s  = PENDING;
          next_id_s     = winner_s;
          next_sec_s    = win_sec_s;
          next_onehot_s = {{(NUM_IRQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
          next_sec_s    = 1'b0;
          next_onehot_s = '0;
        end
      end
      PENDING: begin
        // Ack wins over kill; the id is left in place after either.
        if (bus.ctrl_ack_i) begin
          next_state_s  = DONE;
          next_sec_s    = 1'b0;
          next_onehot_s = '0;
        end else if (bus.ctrl_kill_i) begin
          next_state_s  = IDLE;
          next_sec_s    = 1'b0;
          next_onehot_s = '0;
        end else begin
          next_state_s  = PENDING;
        end
      end
      DONE: begin
        next_state_s  = IDLE;
        next_sec_s    = 1'b0;
        next_onehot_s = '0;
      end
      default: begin
        next_state_s  = IDLE;
        next_sec_s    = 1'b0;
        next_onehot_s = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      req_r     <= 1'b0;
      id_r      <= '0;
      sec_r     <= 1'b0;
      onehot_r  <= '0;
      pending_r <= '0;
    end else begin
      state_r   <= next_state_s;
      req_r     <= (next_state_s == PENDING);
      id_r      <= next_id_s;
      sec_r     <= next_sec_s;
      onehot_r  <= next_onehot_s;
      pending_r <= bus.irq_i & bus.irq_mask_i;
    end
  end

  assign bus.irq_req_o     = req_r;
  assign bus.irq_id_o      = id_r;
  assign bus.irq_sec_o     = sec_r;
  assign bus.irq_onehot_o  = onehot_r;
  assign bus.irq_pending_o = pending_r;
endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Directed bench for riscv_irq_arbiter: a cycle-by-cycle vector table on the
// non-secure build plus hand sequences for reset, kill/recapture and secure mode.
module tb_riscv_irq_arbiter;
  localparam logic [31:0] ALL  = 32'hFFFF_FFFF;
  localparam logic [31:0] NO24 = 32'hFEFF_FFFF;

  typedef struct {
    string       name;
    logic [31:0] irq;
    logic [31:0] mask;
    logic [31:0] sec;
    logic        m_ie;
    logic        ack;
    logic        kill;
    logic        exp_req;
    logic [4:0]  exp_id;
    logic [31:0] exp_oh;
    logic        exp_sec;
    logic [31:0] exp_pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq, mask, sec;
  logic        m_ie, u_ie, ack, kill;
  logic [1:0]  priv;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        vq[$];

  riscv_irq_arbiter_if #(.NUM_IRQ(32)) bus0 ();
  riscv_irq_arbiter_if #(.NUM_IRQ(32)) bus1 ();

  assign bus0.irq_i = irq;  assign bus0.irq_mask_i = mask; assign bus0.irq_sec_i = sec;
  assign bus0.m_ie_i = m_ie; assign bus0.u_ie_i = u_ie;   assign bus0.priv_lvl_i = priv;
  assign bus0.ctrl_ack_i = ack; assign bus0.ctrl_kill_i = kill;
  assign bus1.irq_i = irq;  assign bus1.irq_mask_i = mask; assign bus1.irq_sec_i = sec;
  assign bus1.m_ie_i = m_ie; assign bus1.u_ie_i = u_ie;   assign bus1.priv_lvl_i = priv;
  assign bus1.ctrl_ack_i = ack; assign bus1.ctrl_kill_i = kill;

  riscv_irq_arbiter #(.NUM_IRQ(32), .PULP_SECURE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  riscv_irq_arbiter #(.NUM_IRQ(32), .PULP_SECURE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all0(input string name, input logic req, input logic [4:0] id,
                          input logic s, input logic [31:0] oh, input logic [31:0] pend);
    chk({name, "_req"}, 64'(req), 64'd0);
    chk({name, "_id"}, 64'(id), 64'd0);
    chk({name, "_sec"}, 64'(s), 64'd0);
    chk({name, "_oh"}, 64'(oh), 64'd0);
    chk({name, "_pend"}, 64'(pend), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    irq = v.irq; mask = v.mask; sec = v.sec; m_ie = v.m_ie; ack = v.ack; kill = v.kill;
    step();
    chk({v.name, "_req"}, 64'(bus0.irq_req_o), 64'(v.exp_req));
    chk({v.name, "_id"}, 64'(bus0.irq_id_o), 64'(v.exp_id));
    chk({v.name, "_oh"}, 64'(bus0.irq_onehot_o), 64'(v.exp_oh));
    chk({v.name, "_sec"}, 64'(bus0.irq_sec_o), 64'(v.exp_sec));
    chk({v.name, "_pend"}, 64'(bus0.irq_pending_o), 64'(v.exp_pend));
  endtask

  initial begin
    // name, irq, mask, sec, m_ie, ack, kill | req, id, onehot, sec, pending
    vq.push_back('{"idle",     32'h0,          ALL,  32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,          1'b0, 32'h0});
    vq.push_back('{"cap11",    32'h0000_0800,  ALL,  32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_0800,  1'b0, 32'h0000_0800});
    vq.push_back('{"hold11",   32'h0,          ALL,  32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_0800,  1'b0, 32'h0});
    vq.push_back('{"ack11",    32'h0,          ALL,  32'h0,          1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 32'h0,          1'b0, 32'h0});
    vq.push_back('{"idle2",    32'h0,          ALL,  32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 32'h0,          1'b0, 32'h0});
    vq.push_back('{"cap20",    32'h0010_0088,  ALL,  32'h0010_0000,  1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 32'h0010_0000,  1'b1, 32'h0010_0088});
    vq.push_back('{"drop20",   32'h0000_0088,  ALL,  32'h0010_0000,  1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 32'h0010_0000,  1'b1, 32'h0000_0088});
    vq.push_back('{"hi31",     32'h8000_0088,  ALL,  32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 32'h0010_0000,  1'b1, 32'h8000_0088});
    vq.push_back('{"ackkill",  32'h0000_0088,  ALL,  32'h0,          1'b1, 1'b1, 1'b1, 1'b0, 5'd20, 32'h0,          1'b0, 32'h0000_0088});
    vq.push_back('{"doneack",  32'h0000_0088,  ALL,  32'h0,          1'b1, 1'b1, 1'b0, 1'b0, 5'd20, 32'h0,          1'b0, 32'h0000_0088});
    vq.push_back('{"cap7",     32'h0000_0088,  ALL,  32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  32'h0000_0080,  1'b0, 32'h0000_0088});
    vq.push_back('{"kill7",    32'h0,          ALL,  32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 5'd7,  32'h0,          1'b0, 32'h0});
    vq.push_back('{"idlekill", 32'h0,          ALL,  32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 5'd7,  32'h0,          1'b0, 32'h0});
    vq.push_back('{"mask24",   32'h0100_0000,  NO24, 32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 5'd7,  32'h0,          1'b0, 32'h0});
    vq.push_back('{"cap2",     32'h0100_0004,  NO24, 32'h0000_0004,  1'b1, 1'b0, 1'b0, 1'b1, 5'd2,  32'h0000_0004,  1'b1, 32'h0000_0004});
    vq.push_back('{"ack2",     32'h0100_0000,  ALL,  32'h0,          1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  32'h0,          1'b0, 32'h0100_0000});
    vq.push_back('{"doneoff",  32'h0100_0000,  ALL,  32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  32'h0,          1'b0, 32'h0100_0000});
    vq.push_back('{"mieoff",   32'h0100_0000,  ALL,  32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  32'h0,          1'b0, 32'h0100_0000});
    vq.push_back('{"cap24",    32'h0100_0000,  ALL,  32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 5'd24, 32'h0100_0000,  1'b0, 32'h0100_0000});

    rst_n = 1'b0; irq = '0; mask = ALL; sec = '0;
    m_ie = 1'b1; u_ie = 1'b0; priv = 2'b11; ack = 1'b0; kill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all0("por0", bus0.irq_req_o, bus0.irq_id_o, bus0.irq_sec_o, bus0.irq_onehot_o, bus0.irq_pending_o);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) apply(vq[i]);

    // Reset while PENDING on id 24: outputs clear before the next edge.
    step();
    chk("pend24_req", 64'(bus0.irq_req_o), 64'd1);
    #2;
    rst_n = 1'b0;
    irq   = '0;
    #1;
    chk_all0("arst0", bus0.irq_req_o, bus0.irq_id_o, bus0.irq_sec_o, bus0.irq_onehot_o, bus0.irq_pending_o);
    chk_all0("arst1", bus1.irq_req_o, bus1.irq_id_o, bus1.irq_sec_o, bus1.irq_onehot_o, bus1.irq_pending_o);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("noreplay_req", 64'(bus0.irq_req_o), 64'd0);

    // First capture after reset, then kill with the line still high.
    @(negedge clk); irq = 32'h0001_0000;
    step();
    chk("cap16_req", 64'(bus0.irq_req_o), 64'd1);
    chk("cap16_id", 64'(bus0.irq_id_o), 64'd16);
    chk("cap16_oh", 64'(bus0.irq_onehot_o), 64'h0001_0000);
    @(negedge clk); kill = 1'b1;
    step();
    chk("kill16_req", 64'(bus0.irq_req_o), 64'd0);
    chk("kill16_oh", 64'(bus0.irq_onehot_o), 64'd0);
    chk("kill16_id", 64'(bus0.irq_id_o), 64'd16);
    @(negedge clk); kill = 1'b0;
    step();
    chk("recap16_req", 64'(bus0.irq_req_o), 64'd1);
    chk("recap16_id", 64'(bus0.irq_id_o), 64'd16);
    chk("recap16_oh", 64'(bus0.irq_onehot_o), 64'h0001_0000);
    @(negedge clk); ack = 1'b1; irq = '0;
    step();
    @(negedge clk); ack = 1'b0;
    step();
    chk("sec_pre_req", 64'(bus1.irq_req_o), 64'd0);

    // Secure build in user mode with u_ie low: only secure lines are taken.
    @(negedge clk); priv = 2'b00; u_ie = 1'b0; irq = 32'h0000_0020; sec = '0;
    step();
    chk("u_nsec_req", 64'(bus1.irq_req_o), 64'd0);
    chk("u_nsec_oh", 64'(bus1.irq_onehot_o), 64'd0);
    @(negedge clk); sec = 32'h0000_0020;
    step();
    chk("u_sec_req", 64'(bus1.irq_req_o), 64'd1);
    chk("u_sec_id", 64'(bus1.irq_id_o), 64'd5);
    chk("u_sec_sec", 64'(bus1.irq_sec_o), 64'd1);
    chk("u_sec_oh", 64'(bus1.irq_onehot_o), 64'h0000_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
